// File: rtl/rr_priority_arbiter.sv
// Round-robin arbiter with a one-hot rotating priority pointer and registered grants.
// Grants are held until acked or withdrawn; ack reloads the next winner with no bubble.
module rr_priority_arbiter #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned ROTATE_MODE = 1,
  parameter int unsigned IDW         = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] req,
  input  logic             ack,
  output logic [WIDTH-1:0] grant,
  output logic             grant_valid,
  output logic [IDW-1:0]   grant_id,
  output logic [WIDTH-1:0] prio
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state;
  logic [WIDTH-1:0] prio_rot;
  logic [WIDTH-1:0] win_idle;
  logic [WIDTH-1:0] win_ack;
  logic [WIDTH-1:0] hold_mask;

  function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] x);
    return {x[WIDTH-2:0], x[WIDTH-1]};
  endfunction

  // First set request at or above the pointer, else the lowest set request (wrap-around).
  function automatic logic [WIDTH-1:0] pick(input logic [WIDTH-1:0] r,
                                            input logic [WIDTH-1:0] p);
    logic [WIDTH-1:0] upper;
    upper = r & ~(p - WIDTH'(1));
    if (upper != '0) return upper & (~upper + WIDTH'(1));
    return r & (~r + WIDTH'(1));
  endfunction

  function automatic logic [IDW-1:0] onehot_to_id(input logic [WIDTH-1:0] oh);
    logic [IDW-1:0] id;
    id = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (oh[i]) id = id | IDW'(i);
    end
    return id;
  endfunction

  always_comb begin
    prio_rot  = (ROTATE_MODE != 0) ? rotl(grant) : rotl(prio);
    win_idle  = pick(req, prio);
    win_ack   = pick(req, prio_rot);
    hold_mask = req & grant;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      prio        <= WIDTH'(1);
    end else begin
      case (state)
        IDLE: begin
          if (win_idle != '0) begin
            state       <= GRANT;
            grant       <= win_idle;
            grant_valid <= 1'b1;
            grant_id    <= onehot_to_id(win_idle);
          end
        end
        GRANT: begin
          if (ack) begin
            prio <= prio_rot;
            if (win_ack != '0) begin
              grant       <= win_ack;
              grant_valid <= 1'b1;
              grant_id    <= onehot_to_id(win_ack);
            end else begin
              state       <= IDLE;
              grant       <= '0;
              grant_valid <= 1'b0;
              grant_id    <= '0;
            end
          end else if (hold_mask == '0) begin
            // Requester withdrew; re-arbitrate from IDLE next cycle.
            state       <= IDLE;
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_id    <= '0;
          end
        end
        default: begin
          state       <= IDLE;
          grant       <= '0;
          grant_valid <= 1'b0;
          grant_id    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_priority_arbiter.sv
// Bench for rr_priority_arbiter: two WIDTH=4 instances (skip-past-winner and rotate-by-one)
// driven by shared directed and random stimulus, checked against an index-based model.
module tb_rr_priority_arbiter;

  localparam int W  = 4;
  localparam int IW = 2;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [W-1:0]  req   = '0;
  logic          ack   = 1'b0;

  logic [W-1:0]  g1, p1, g0, p0;
  logic          v1, v0;
  logic [IW-1:0] i1, i0;

  int checks = 0;
  int errors = 0;

  // Model state per instance: [0] = ROTATE_MODE 1, [1] = ROTATE_MODE 0.
  int mp[2] = '{0, 0};
  int mg[2] = '{-1, -1};

  rr_priority_arbiter #(.WIDTH(W), .ROTATE_MODE(1)) dut_skip (
    .clock(clock), .reset(reset), .req(req), .ack(ack),
    .grant(g1), .grant_valid(v1), .grant_id(i1), .prio(p1)
  );

  rr_priority_arbiter #(.WIDTH(W), .ROTATE_MODE(0)) dut_step (
    .clock(clock), .reset(reset), .req(req), .ack(ack),
    .grant(g0), .grant_valid(v0), .grant_id(i0), .prio(p0)
  );

  always #5 clock = ~clock;

  function automatic int pick_m(input logic [W-1:0] r, input int p);
    for (int k = 0; k < W; k++) begin
      if (r[(p + k) % W]) return (p + k) % W;
    end
    return -1;
  endfunction

  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        mp[d] = 0;
        mg[d] = -1;
      end else if (mg[d] < 0) begin
        mg[d] = pick_m(req, mp[d]);
      end else if (ack) begin
        mp[d] = (d == 0) ? (mg[d] + 1) % W : (mp[d] + 1) % W;
        mg[d] = pick_m(req, mp[d]);
      end else if (!req[mg[d]]) begin
        mg[d] = -1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int eg[2];
    for (int d = 0; d < 2; d++) eg[d] = (mg[d] < 0) ? 0 : (1 << mg[d]);
    chk("skip_grant", 32'(g1), 32'(eg[0]));
    chk("skip_valid", 32'(v1), 32'(mg[0] >= 0));
    chk("skip_id",    32'(i1), 32'((mg[0] < 0) ? 0 : mg[0]));
    chk("skip_prio",  32'(p1), 32'(1 << mp[0]));
    chk("step_grant", 32'(g0), 32'(eg[1]));
    chk("step_valid", 32'(v0), 32'(mg[1] >= 0));
    chk("step_id",    32'(i0), 32'((mg[1] < 0) ? 0 : mg[1]));
    chk("step_prio",  32'(p0), 32'(1 << mp[1]));
  endtask

  task automatic cyc(input logic rst, input logic [W-1:0] r, input logic a);
    reset = rst;
    req   = r;
    ack   = a;
    @(posedge clock);
    model_step();
    #1;
    check_all();
  endtask

  initial begin
    int seq_g[5];
    int skip_g[3];
    int skip_p[3];
    int step_p[5];
    logic [W-1:0] r;
    seq_g  = '{1, 2, 4, 8, 1};
    skip_g = '{2, 8, 2};
    skip_p = '{1, 4, 1};
    step_p = '{1, 2, 4, 8, 1};

    // Reset held with requests and ack present
    cyc(1'b1, 4'b1111, 1'b1);
    chk("rst_prio", 32'(p1), 32'h1);
    chk("rst_grant", 32'(g1), 32'h0);
    cyc(1'b1, 4'b1111, 1'b1);

    // Fair rotation, one grant per cycle
    for (int k = 0; k < 5; k++) begin
      cyc(1'b0, 4'b1111, 1'b1);
      chk("fair_grant", 32'(g1), 32'(seq_g[k]));
      chk("fair_id", 32'(i1), 32'(k % 4));
    end

    // Skip past the winner
    cyc(1'b1, 4'b0000, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 4'b1010, 1'b1);
      chk("skipw_grant", 32'(g1), 32'(skip_g[k]));
      chk("skipw_prio", 32'(p1), 32'(skip_p[k]));
    end

    // Rotate by one, same requester keeps winning
    cyc(1'b1, 4'b0000, 1'b0);
    for (int k = 0; k < 5; k++) begin
      cyc(1'b0, 4'b1000, 1'b1);
      chk("rot1_grant", 32'(g0), 32'h8);
      chk("rot1_prio", 32'(p0), 32'(step_p[k]));
    end

    // Withdraw
    cyc(1'b1, 4'b0000, 1'b0);
    cyc(1'b0, 4'b0100, 1'b0);
    cyc(1'b0, 4'b0100, 1'b0);
    chk("wd_held", 32'(g1), 32'h4);
    cyc(1'b0, 4'b0001, 1'b0);
    chk("wd_valid", 32'(v1), 32'h0);
    chk("wd_prio", 32'(p1), 32'h1);
    cyc(1'b0, 4'b0001, 1'b0);
    chk("wd_next", 32'(g1), 32'h1);

    // Hold against other requests, then mid-grant reset
    cyc(1'b1, 4'b0000, 1'b0);
    cyc(1'b0, 4'b0010, 1'b0);
    for (int k = 0; k < 5; k++) begin
      r = 4'b0010;
      r[0] = 1'($urandom);
      r[3] = 1'($urandom);
      cyc(1'b0, r, 1'b0);
      chk("hold_grant", 32'(g1), 32'h2);
    end
    cyc(1'b1, 4'b1111, 1'b1);
    chk("mid_rst_valid", 32'(v1), 32'h0);
    chk("mid_rst_prio", 32'(p0), 32'h1);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      r = 4'($urandom);
      if ($urandom_range(0, 7) == 0) r = '0;
      cyc(($urandom_range(0, 59) == 0), r, 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_priority_arbiter.md
# rr_priority_arbiter

Parametrised round-robin arbiter for WIDTH requesters. It generalises the rotating one-hot priority register: the priority pointer can rotate by one position or jump past the last winner. Grants are registered and held until accepted or withdrawn, with a back-to-back ack handshake. It sits between request sources and a shared resource and is the top-level arbitration core of the arbiter design.

## Interface
- WIDTH, 8: number of requesters; must be ≥ 2.
- ROTATE_MODE, 1: pointer update on ack.
  - 0: rotate the pointer left by one.
  - 1: pointer becomes the winner rotated left by one.
- IDW, $clog2(WIDTH): width of grant_id (derived; do not override).

- clock  input  1  sole clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- req  input  WIDTH  request vector; bit i is requester i.
- ack  input  1  the shared resource accepted the current grant; meaningful only while grant_valid=1.
- grant  output  WIDTH  registered one-hot grant, or all-zero.
- grant_valid  output  1  high exactly when grant is non-zero.
- grant_id  output  IDW  binary index of the granted bit; 0 when grant_valid=0.
- priority  output  WIDTH  current one-hot priority pointer; the highest-priority position.

## Operation
- State: a 2-state FSM (IDLE, GRANT) plus the priority register.
  - priority is always one-hot.
  - grant is one-hot or zero.
- Winner selection (combinational):
  - Scan req starting at the set bit of priority, then upward with wrap-around (bit WIDTH-1 → bit 0).
  - The first set bit wins.
  - If req=0, there is no winner.
- IDLE:
  - If a winner exists: load grant=winner, set grant_valid=1, go to GRANT.
  - Otherwise stay in IDLE with grant=0.
  - priority is not modified in IDLE.
- GRANT, ack=1 (takes precedence over withdraw):
  - Update priority per ROTATE_MODE, using the current grant and current priority.
  - Recompute the winner from the current req using the updated priority.
  - If a winner exists: load it and stay in GRANT (back-to-back, no bubble).
  - Otherwise: clear grant, go to IDLE.
- GRANT, ack=0, (req & grant) ≠ 0: hold grant, grant_id and priority unchanged.
- GRANT, ack=0, (req & grant) = 0 (withdraw):
  - Clear grant, go to IDLE; priority is unchanged.
  - A new arbitration happens on the following cycle from IDLE.
- Effect of ROTATE_MODE:
  - ROTATE_MODE=1: the last winner becomes lowest priority.
  - ROTATE_MODE=0: a requester may win consecutively if it remains first in scan order.
- ack while grant_valid=0 is ignored.
- Requests from non-granted requesters never disturb a held grant (no preemption).

## Timing
- Reset values (cycle after reset is sampled high):
  - priority = 1 (bit 0 set); grant = 0; grant_valid = 0; grant_id = 0; FSM = IDLE.
- reset overrides all other inputs, including mid-grant with ack=1.
- Latencies:
  - req asserted in cycle t with the FSM in IDLE → grant visible in cycle t+1.
  - ack in cycle t → the updated priority and the next grant (or 0) are visible in cycle t+1.
  - Withdraw detected in cycle t → grant_valid=0 in t+1 → next grant at the earliest in t+2.
- Throughput: with continuous requests and ack held high, one grant per cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Wrap-around: the scan and the rotate from bit WIDTH-1 go to bit 0.
- grant_id is consistent with grant in the same cycle.

## Test plan
- Reset: WIDTH=4; assert reset for 2 cycles with req=1111, ack=1.
  - → priority=0001, grant=0000, grant_valid=0, grant_id=0 throughout reset and in the cycle after release.
- Fair rotation: ROTATE_MODE=1, req=1111 held, ack=1 every cycle.
  - → grant sequence 0001, 0010, 0100, 1000, 0001.
  - → grant_id sequence 0, 1, 2, 3, 0.
  - → no bubbles.
- Skip-past-winner: ROTATE_MODE=1, req=1010 from reset, ack on every grant.
  - → grant 0010; then priority=0100, grant 1000; then priority=0001, grant 0010.
- Rotate-by-one: ROTATE_MODE=0, req=1000 from reset, ack each grant.
  - → grant 1000 repeatedly.
  - → priority steps 0001 → 0010 → 0100 → 1000 → 0001.
- Withdraw: req=0100, grant=0100 held; drop req to 0001 with ack=0.
  - → next cycle grant_valid=0, priority unchanged.
  - → following cycle grant=0001.
- Hold and mid-operation reset:
  - grant=0010 held 5 cycles with ack=0 while req toggles bits 0 and 3 → grant stays 0010.
  - Then assert reset → next cycle all outputs at reset values.
